// File: rtl/ber_pkg.sv
// Shared constants and state encoding for the BER checker.
// PRBS9 reference polynomial x^9+x^5+1 and default window settings.
package ber_pkg;

  localparam int PRBS_LEN   = 9;
  localparam int TAP_HI     = 8;
  localparam int TAP_LO     = 4;
  localparam int WIN_DEF    = 64;
  localparam int THRESH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } ber_state_e;

endpackage

// File: rtl/prbs9_ref.sv
// Local PRBS9 reference: loads received bits while seeding,
// then free-runs on its own feedback.
module prbs9_ref
  import ber_pkg::*;
(
  input  logic clock,
  input  logic i_reset,
  input  logic i_shift,
  input  logic i_load_mode,
  input  logic i_bit,
  output logic o_expected
);

  logic [PRBS_LEN-1:0] lfsr_q;
  logic [PRBS_LEN-1:0] lfsr_d;
  logic                fb;

  always_comb begin
    fb     = lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO];
    lfsr_d = lfsr_q;
    if (i_shift) begin
      lfsr_d = {lfsr_q[PRBS_LEN-2:0],
                i_load_mode ? i_bit : fb};
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) lfsr_q <= '0;
    else          lfsr_q <= lfsr_d;
  end

  assign o_expected = fb;

endmodule

// File: rtl/ber_checker.sv
// Decimating slicer with self-aligning PRBS9 reference and
// saturating bit/error accumulators for closed-loop BER.
module ber_checker
  import ber_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int NB_PHASE = 3,
  parameter int WIN      = WIN_DEF,
  parameter int THRESH   = THRESH_DEF,
  parameter int NB_CNT   = 32
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_PHASE-1:0] i_phase,
  input  logic                i_clear,
  output logic                o_locked,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count,
  output logic                o_err
);

  localparam int NB_WERR = $clog2(THRESH + 2);
  localparam int CMAX    = (WIN > PRBS_LEN) ? WIN : PRBS_LEN;
  localparam int NB_WCNT = $clog2(CMAX);

  localparam logic [NB_WCNT-1:0] WIN_LAST  = NB_WCNT'(WIN - 1);
  localparam logic [NB_WCNT-1:0] SEED_LAST = NB_WCNT'(PRBS_LEN - 1);
  localparam logic [NB_WERR-1:0] THR       = NB_WERR'(THRESH);

  ber_state_e          state_q, state_d;
  logic [NB_PHASE-1:0] phase_q, phase_d;
  logic                rx_bit_q, rx_bit_d;
  logic                sym_q, sym_d;
  logic [NB_WCNT-1:0]  wcnt_q, wcnt_d;
  logic [NB_WERR-1:0]  werr_q, werr_d;
  logic [NB_WERR-1:0]  werr_nxt;
  logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;

  logic active;
  logic strobe;
  logic shift;
  logic expected;
  logic mismatch;
  logic win_end;
  logic unused_data;

  assign unused_data = ^i_data[NB_DATA-2:0];

  assign active   = i_enable && (state_q != IDLE);
  assign strobe   = active && i_valid && (phase_q == i_phase);
  assign shift    = active && sym_q;
  assign mismatch = rx_bit_q ^ expected;
  assign win_end  = (wcnt_q == WIN_LAST);

  prbs9_ref u_ref (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_shift     (shift),
    .i_load_mode (state_q == SEED),
    .i_bit       (rx_bit_q),
    .o_expected  (expected)
  );

  always_comb begin
    phase_d = phase_q;
    if (!active)      phase_d = '0;
    else if (i_valid) phase_d = phase_q + NB_PHASE'(1);

    rx_bit_d = rx_bit_q;
    if (strobe) rx_bit_d = i_data[NB_DATA-1];
    sym_d = strobe;

    werr_nxt = werr_q;
    if (mismatch && (werr_q != '1)) werr_nxt = werr_q + NB_WERR'(1);
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;

    if (!i_enable) begin
      state_d = IDLE;
      wcnt_d  = '0;
      werr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SEED;
          wcnt_d  = '0;
          werr_d  = '0;
        end
        SEED: begin
          if (sym_q) begin
            if (wcnt_q == SEED_LAST) begin
              state_d = VERIFY;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + NB_WCNT'(1);
            end
          end
        end
        VERIFY, LOCKED: begin
          if (sym_q) begin
            werr_d = werr_nxt;
            wcnt_d = wcnt_q + NB_WCNT'(1);
            if (state_q == LOCKED) begin
              if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + NB_CNT'(1);
              if (mismatch) begin
                err_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + NB_CNT'(1);
              end
            end
            if (win_end) begin
              wcnt_d  = '0;
              werr_d  = '0;
              state_d = (werr_nxt > THR) ? SEED : LOCKED;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear overrides any count made in the same cycle.
    if (i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      rx_bit_q  <= 1'b0;
      sym_q     <= 1'b0;
      wcnt_q    <= '0;
      werr_q    <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rx_bit_q  <= rx_bit_d;
      sym_q     <= sym_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;
  assign o_err       = err_q;

endmodule
